serial_deser_rx: RTL and testbench
==================================

Name: serial_deser_rx

Overview:
- Receive end of the team's 1-bit registered data path: collects a serial bit stream (din/din_valid) into WIDTH-bit words.
- Presents each word on a parallel valid/ready port.
- One-word holding register decouples shifting from the consumer; sticky overrun flag for dropped words.
- Sits downstream of the single-bit flop stage, feeding word-level scoreboards/consumers.

Parameters:
WIDTH, 8, bits per word (2..32)
LSB_FIRST, 0, 0 = first received bit lands in dout[WIDTH-1]; 1 = first bit lands in dout[0]

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
din  in  1  serial data bit
din_valid  in  1  din is sampled on this edge when 1
flush  in  1  synchronous: discard partial word, counter to 0
dout  out  WIDTH  assembled word (holding register)
dout_valid  out  1  holding register full
dout_ready  in  1  consumer accepts dout when dout_valid && dout_ready
bit_cnt  out  $clog2(WIDTH+1)  bits collected in current partial word
overrun  out  1  sticky: a completed word was dropped
clr_ovr  in  1  synchronous clear of overrun

Behaviour:
- Reset (rst=0, async assert, sync deassert by the system): shift reg=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0. Reset mid-word discards the partial word and the held word.
- Shift: on edge with din_valid=1 and flush=0, the bit enters the shift register (MSB-first: shift left, din into bit 0; LSB_FIRST: shift right, din into bit WIDTH-1); bit_cnt increments.
- Completion: the edge accepting bit number WIDTH (bit_cnt==WIDTH-1 && din_valid) is the completing edge. On it, the full word (including that bit) is offered to the holding register and bit_cnt wraps to 0. The shift register needs no clear; the next word overwrites it.
- Latency: dout_valid=1 in the cycle after the completing edge; dout stable while dout_valid=1 and not accepted.
- Holding register states: EMPTY (dout_valid=0), FULL (dout_valid=1).
  - EMPTY + completing edge -> FULL.
  - FULL + dout_ready + no completion -> EMPTY.
  - FULL + dout_ready + completion same edge -> stays FULL with the new word (back-to-back, no bubble).
  - FULL + !dout_ready + completion -> stays FULL with the old word, new word dropped, overrun<=1.
- Continuous streaming: din_valid=1 every cycle with dout_ready=1 sustains 1 word per WIDTH cycles with no loss.
- flush=1: bit_cnt<=0 and partial word discarded. The holding register is unaffected and a handshake on the same edge still completes. flush has priority over din_valid, so no bit is accepted on a flush edge.
- clr_ovr=1: overrun<=0, unless an overrun occurs on the same edge (set wins).
- dout_ready is ignored while dout_valid=0.
- dout/dout_valid/overrun/bit_cnt are direct register outputs with no combinational path from inputs.

Decomposition:
- Package serial_pkg holds:
  - bit_order_e {MSB_FIRST, LSB_FIRST}
  - DEFAULT_WIDTH=8
  - hold_state_e {EMPTY, FULL}
- Natural sub-module deser_shift_reg contains the shift register plus bit counter and outputs word + done pulse.
- Top contains the holding register FSM and overrun logic.

Test Plan:
- Reset then 8 bits 1,0,1,1,0,0,1,0 with din_valid=1 (WIDTH=8, MSB-first), dout_ready=1 -> dout=8'hB2, dout_valid=1 for exactly 1 cycle, one cycle after the 8th bit edge; bit_cnt 0..7 then 0.
- Same bits with LSB_FIRST=1 -> dout=8'h4D.
- Two words 8'hA5, 8'h3C streamed back-to-back with dout_ready=0 throughout -> dout holds 8'hA5, overrun=1 after the 16th bit; clr_ovr pulse -> overrun=0, dout still 8'hA5.
- Word 8'hA5 held, dout_ready=1 on the edge completing 8'h3C -> no overrun, dout=8'h3C next cycle, dout_valid stays 1.
- 5 bits, flush pulse, then 8 bits 8'hFF -> dout=8'hFF, no partial-bit contamination; bit_cnt=0 right after the flush.
- rst asserted after 4 bits with 8'h81 held -> all outputs 0 immediately (async), and the next 8 bits of 8'h0F yield dout=8'h0F.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial receive deserializer.
package serial_pkg;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } bit_order_e;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_e;

endpackage

// File: rtl/deser_shift_reg.sv
// Shift register and bit counter; emits the assembled word with a done pulse
// on the edge that accepts the last bit of a word.
module deser_shift_reg
    import serial_pkg::*;
#(
    parameter int         WIDTH = DEFAULT_WIDTH,
    parameter bit_order_e ORDER = MSB_FIRST
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       din,
    input  logic                       din_valid,
    input  logic                       flush,
    output logic [WIDTH-1:0]           word,
    output logic                       done,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_next_s;
    logic [CW-1:0]    bit_cnt_r;
    logic             take_s;

    // Next shift value; word is offered combinationally so the completing bit is included.
    always_comb begin
        shift_next_s = shift_r;
        if (ORDER == LSB_FIRST) begin
            shift_next_s = {din, shift_r[WIDTH-1:1]};
        end else begin
            shift_next_s = {shift_r[WIDTH-2:0], din};
        end
    end

    assign take_s  = din_valid && !flush;
    assign done    = take_s && (bit_cnt_r == CW'(WIDTH - 1));
    assign word    = shift_next_s;
    assign bit_cnt = bit_cnt_r;

    // Shift register and bit counter; flush beats din_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= {CW{1'b0}};
        end else begin
            if (take_s) begin
                shift_r <= shift_next_s;
            end
            if (flush) begin
                bit_cnt_r <= {CW{1'b0}};
            end else if (take_s) begin
                bit_cnt_r <= done ? {CW{1'b0}} : bit_cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/serial_deser_rx.sv
// Serial-to-parallel receiver: shift stage plus a one-word holding register
// with valid/ready output and sticky overrun on dropped words.
module serial_deser_rx
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int LSB_FIRST = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din,
    input  logic                       din_valid,
    input  logic                       flush,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       overrun,
    input  logic                       clr_ovr
);

    localparam bit_order_e ORDER = (LSB_FIRST != 0) ? serial_pkg::LSB_FIRST
                                                    : serial_pkg::MSB_FIRST;

    logic [WIDTH-1:0] word_s;
    logic             done_s;
    hold_state_e      state_r;
    hold_state_e      state_next_s;
    logic [WIDTH-1:0] dout_r;
    logic [WIDTH-1:0] dout_next_s;
    logic             dout_valid_r;
    logic             overrun_r;
    logic             overrun_next_s;
    logic             drop_s;

    deser_shift_reg #(
        .WIDTH (WIDTH),
        .ORDER (ORDER)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst),
        .din       (din),
        .din_valid (din_valid),
        .flush     (flush),
        .word      (word_s),
        .done      (done_s),
        .bit_cnt   (bit_cnt)
    );

    // Holding register next state; a completion while full and stalled drops the new word.
    always_comb begin
        state_next_s = state_r;
        dout_next_s  = dout_r;
        drop_s       = 1'b0;
        case (state_r)
            EMPTY: begin
                if (done_s) begin
                    state_next_s = FULL;
                    dout_next_s  = word_s;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            FULL: begin
                if (done_s) begin
                    state_next_s = FULL;
                    if (dout_ready) begin
                        dout_next_s = word_s;
                    end else begin
                        drop_s = 1'b1;
                    end
                end else if (dout_ready) begin
                    state_next_s = EMPTY;
                end else begin
                    state_next_s = FULL;
                end
            end
            default: begin
                state_next_s = EMPTY;
            end
        endcase
    end

    // Sticky overrun: a drop on the same edge wins over clear.
    always_comb begin
        overrun_next_s = overrun_r;
        if (drop_s) begin
            overrun_next_s = 1'b1;
        end else if (clr_ovr) begin
            overrun_next_s = 1'b0;
        end else begin
            overrun_next_s = overrun_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= EMPTY;
            dout_r       <= {WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            dout_r       <= dout_next_s;
            dout_valid_r <= (state_next_s == FULL);
            overrun_r    <= overrun_next_s;
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_serial_deser_rx.sv
// Directed bench: MSB-first and LSB-first receivers driven by the same stream.
module tb_serial_deser_rx;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       flush;
    logic       dout_ready;
    logic       clr_ovr;
    logic [7:0] dout_m, dout_l;
    logic       dv_m, dv_l;
    logic [3:0] cnt_m, cnt_l;
    logic       ovr_m, ovr_l;

    int errors = 0;
    int checks = 0;

    serial_deser_rx #(.WIDTH(8), .LSB_FIRST(0)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .flush(flush),
        .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
        .bit_cnt(cnt_m), .overrun(ovr_m), .clr_ovr(clr_ovr)
    );

    serial_deser_rx #(.WIDTH(8), .LSB_FIRST(1)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .flush(flush),
        .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
        .bit_cnt(cnt_l), .overrun(ovr_l), .clr_ovr(clr_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send bits of w from bit 7 downward, n bits, din_valid held high.
    task automatic send(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            din       = w[7-i];
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        din       = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        rst = 1'b0; din = 1'b0; din_valid = 1'b0; flush = 1'b0;
        dout_ready = 1'b1; clr_ovr = 1'b0;
        #2;
        chk("rst_dout", {24'd0, dout_m}, 32'd0);
        chk("rst_dv", {31'd0, dv_m}, 32'd0);
        chk("rst_cnt", {28'd0, cnt_m}, 32'd0);
        chk("rst_ovr", {31'd0, ovr_m}, 32'd0);
        #10 rst = 1'b1;

        // 1,0,1,1,0,0,1,0 -> B2 MSB-first, 4D LSB-first
        pat = 8'hB2;
        for (int i = 0; i < 8; i++) begin
            din = pat[7-i];
            din_valid = 1'b1;
            tick();
            chk("cnt_walk", {28'd0, cnt_m}, (i + 1) % 8);
            if (i == 6) chk("dv_before_last", {31'd0, dv_m}, 32'd0);
        end
        din_valid = 1'b0;
        chk("b2_dv", {31'd0, dv_m}, 32'd1);
        chk("b2_dout", {24'd0, dout_m}, 32'hB2);
        chk("4d_dout", {24'd0, dout_l}, 32'h4D);
        chk("4d_dv", {31'd0, dv_l}, 32'd1);
        tick();
        chk("b2_dv_one_cycle", {31'd0, dv_m}, 32'd0);

        // Two words with consumer stalled: second is dropped
        dout_ready = 1'b0;
        send(8'hA5, 8);
        chk("a5_dout", {24'd0, dout_m}, 32'hA5);
        chk("a5_ovr0", {31'd0, ovr_m}, 32'd0);
        send(8'h3C, 8);
        chk("drop_dout", {24'd0, dout_m}, 32'hA5);
        chk("drop_dv", {31'd0, dv_m}, 32'd1);
        chk("drop_ovr", {31'd0, ovr_m}, 32'd1);
        chk("drop_ovr_l", {31'd0, ovr_l}, 32'd1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("clr_ovr", {31'd0, ovr_m}, 32'd0);
        chk("clr_dout", {24'd0, dout_m}, 32'hA5);

        // Accept on the completing edge: back-to-back replace, no overrun
        send(8'h3C, 7);
        din = 1'b0; din_valid = 1'b1; dout_ready = 1'b1;
        tick();
        din_valid = 1'b0; dout_ready = 1'b0;
        chk("b2b_dout", {24'd0, dout_m}, 32'h3C);
        chk("b2b_dv", {31'd0, dv_m}, 32'd1);
        chk("b2b_ovr", {31'd0, ovr_m}, 32'd0);
        dout_ready = 1'b1;
        tick();
        chk("drain_dv", {31'd0, dv_m}, 32'd0);

        // Partial word then flush (with din_valid high) then FF
        send(8'hA8, 5);
        chk("partial_cnt", {28'd0, cnt_m}, 32'd5);
        flush = 1'b1; din = 1'b1; din_valid = 1'b1;
        tick();
        flush = 1'b0; din_valid = 1'b0;
        chk("flush_cnt", {28'd0, cnt_m}, 32'd0);
        chk("flush_dv", {31'd0, dv_m}, 32'd0);
        dout_ready = 1'b0;
        send(8'hFF, 7);
        chk("ff_not_early", {31'd0, dv_m}, 32'd0);
        send(8'h80, 1);
        chk("ff_dout", {24'd0, dout_m}, 32'hFF);
        chk("ff_dv", {31'd0, dv_m}, 32'd1);

        // Async reset mid-word with 81 held
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        send(8'h81, 8);
        chk("81_dout", {24'd0, dout_m}, 32'h81);
        send(8'hC0, 4);
        chk("81_partial", {28'd0, cnt_m}, 32'd4);
        #2 rst = 1'b0;
        #1;
        chk("arst_dout", {24'd0, dout_m}, 32'd0);
        chk("arst_dv", {31'd0, dv_m}, 32'd0);
        chk("arst_cnt", {28'd0, cnt_m}, 32'd0);
        chk("arst_dv_l", {31'd0, dv_l}, 32'd0);
        #1 rst = 1'b1;
        tick();
        send(8'h0F, 8);
        chk("0f_dout", {24'd0, dout_m}, 32'h0F);
        chk("0f_dv", {31'd0, dv_m}, 32'd1);
        chk("0f_ovr", {31'd0, ovr_m}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
